// File: rtl/morse_char_decoder.sv
// rtl/morse_char_decoder.sv - Morse dot/dash pattern to ASCII decoder with output FIFO
module morse_char_decoder #(
    parameter int          FIFO_DEPTH      = 8,
    parameter bit          REPLACE_INVALID = 1'b1,
    parameter logic [7:0]  SPACE_CHAR      = 8'h20,
    localparam int MORSE_CHAR_WIDTH_MAX_C = 5,
    localparam int MORSE_SIZE_WIDTH_MAX_C = 3,
    localparam int AW                     = $clog2(FIFO_DEPTH),
    localparam int LW                     = AW + 1
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              s_tvalid_i,
    input  logic [MORSE_CHAR_WIDTH_MAX_C-1:0] s_tdata_i,
    input  logic [MORSE_SIZE_WIDTH_MAX_C-1:0] s_tsize_i,
    output logic                              m_tvalid_o,
    output logic [7:0]                        m_tdata_o,
    input  logic                              m_tready_i,
    output logic                              invalid_o,
    output logic                              overflow_o,
    output logic [7:0]                        drop_cnt_o,
    output logic [LW-1:0]                     level_o
);

    localparam logic [7:0] INVALID_CHAR = 8'h3F;

    // Returns {bad, byte}; the pattern's first symbol sits at bit size-1, dash = 1.
    function automatic logic [8:0] morse_lookup(
        input logic [MORSE_SIZE_WIDTH_MAX_C-1:0] size,
        input logic [MORSE_CHAR_WIDTH_MAX_C-1:0] pat
    );
        logic [7:0] ch;
        logic       bad;
        ch  = 8'h00;
        bad = 1'b0;
        case (size)
            3'd0: ch = SPACE_CHAR;
            3'd1: ch = pat[0] ? 8'h54 : 8'h45;
            3'd2: begin
                case (pat[1:0])
                    2'b00:   ch = 8'h49;
                    2'b01:   ch = 8'h41;
                    2'b10:   ch = 8'h4E;
                    default: ch = 8'h4D;
                endcase
            end
            3'd3: begin
                case (pat[2:0])
                    3'b000:  ch = 8'h53;
                    3'b001:  ch = 8'h55;
                    3'b010:  ch = 8'h52;
                    3'b011:  ch = 8'h57;
                    3'b100:  ch = 8'h44;
                    3'b101:  ch = 8'h4B;
                    3'b110:  ch = 8'h47;
                    default: ch = 8'h4F;
                endcase
            end
            3'd4: begin
                case (pat[3:0])
                    4'b0000: ch = 8'h48;
                    4'b0001: ch = 8'h56;
                    4'b0010: ch = 8'h46;
                    4'b0100: ch = 8'h4C;
                    4'b0110: ch = 8'h50;
                    4'b0111: ch = 8'h4A;
                    4'b1000: ch = 8'h42;
                    4'b1001: ch = 8'h58;
                    4'b1010: ch = 8'h43;
                    4'b1011: ch = 8'h59;
                    4'b1100: ch = 8'h5A;
                    4'b1101: ch = 8'h51;
                    default: bad = 1'b1;
                endcase
            end
            3'd5: begin
                case (pat)
                    5'b11111: ch = 8'h30;
                    5'b01111: ch = 8'h31;
                    5'b00111: ch = 8'h32;
                    5'b00011: ch = 8'h33;
                    5'b00001: ch = 8'h34;
                    5'b00000: ch = 8'h35;
                    5'b10000: ch = 8'h36;
                    5'b11000: ch = 8'h37;
                    5'b11100: ch = 8'h38;
                    5'b11110: ch = 8'h39;
                    default:  bad = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase
        return {bad, bad ? INVALID_CHAR : ch};
    endfunction

    logic       s1_valid;
    logic       s1_bad;
    logic [7:0] s1_byte;
    logic [8:0] lookup;

    always_comb begin
        lookup = morse_lookup(s_tsize_i, s_tdata_i);
    end

    // Stage 1 never stalls: each beat simply overwrites the previous result.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_bad   <= 1'b0;
            s1_byte  <= 8'h00;
        end else begin
            s1_valid <= s_tvalid_i;
            if (s_tvalid_i) begin
                s1_bad  <= lookup[8];
                s1_byte <= lookup[7:0];
            end
        end
    end

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          full;
    logic          push;
    logic          pop;
    logic          do_push;
    logic          drop;

    always_comb begin
        full    = (level == LW'(FIFO_DEPTH));
        push    = s1_valid && (!s1_bad || REPLACE_INVALID);
        pop     = m_tvalid_o && m_tready_i;
        do_push = push && (!full || pop);
        drop    = push && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= s1_byte;
        end
    end

    // Occupancy is tracked explicitly so full and empty never alias on pointer equality.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow_o <= 1'b0;
            drop_cnt_o <= 8'h00;
            invalid_o  <= 1'b0;
        end else begin
            invalid_o <= s_tvalid_i && lookup[8];
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop) begin
                overflow_o <= 1'b1;
                if (drop_cnt_o != 8'hFF) begin
                    drop_cnt_o <= drop_cnt_o + 8'd1;
                end
            end
        end
    end

    always_comb begin
        m_tvalid_o = (level != '0);
        m_tdata_o  = m_tvalid_o ? mem[rd_ptr] : 8'h00;
        level_o    = level;
    end

endmodule

// File: tb/tb_morse_char_decoder.sv
// tb/tb_morse_char_decoder.sv - directed self-checking bench for morse_char_decoder
module tb_morse_char_decoder;

    logic       clk;
    logic       resetn;
    logic       s_tvalid;
    logic [4:0] s_tdata;
    logic [2:0] s_tsize;
    logic       m_tvalid;
    logic [7:0] m_tdata;
    logic       m_tready;
    logic       invalid;
    logic       overflow;
    logic [7:0] drop_cnt;
    logic [3:0] level;

    logic       nr_tvalid;
    logic [4:0] nr_tdata;
    logic [2:0] nr_tsize;
    logic       nr_m_tvalid;
    logic [7:0] nr_m_tdata;
    logic       nr_m_tready;
    logic       nr_invalid;
    logic       nr_overflow;
    logic [7:0] nr_drop_cnt;
    logic [3:0] nr_level;

    int n_total = 0;
    int n_bad   = 0;
    int inv_cnt = 0;
    int nr_inv_cnt = 0;
    logic [7:0] cap_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] nr_cap_q[$];

    morse_char_decoder #(.FIFO_DEPTH(8), .REPLACE_INVALID(1'b1), .SPACE_CHAR(8'h20)) dut (
        .clk(clk), .resetn(resetn),
        .s_tvalid_i(s_tvalid), .s_tdata_i(s_tdata), .s_tsize_i(s_tsize),
        .m_tvalid_o(m_tvalid), .m_tdata_o(m_tdata), .m_tready_i(m_tready),
        .invalid_o(invalid), .overflow_o(overflow), .drop_cnt_o(drop_cnt), .level_o(level)
    );

    morse_char_decoder #(.FIFO_DEPTH(8), .REPLACE_INVALID(1'b0), .SPACE_CHAR(8'h20)) dut_nr (
        .clk(clk), .resetn(resetn),
        .s_tvalid_i(nr_tvalid), .s_tdata_i(nr_tdata), .s_tsize_i(nr_tsize),
        .m_tvalid_o(nr_m_tvalid), .m_tdata_o(nr_m_tdata), .m_tready_i(nr_m_tready),
        .invalid_o(nr_invalid), .overflow_o(nr_overflow), .drop_cnt_o(nr_drop_cnt), .level_o(nr_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (m_tvalid && m_tready) cap_q.push_back(m_tdata);
        if (invalid) inv_cnt++;
        if (nr_m_tvalid && nr_m_tready) nr_cap_q.push_back(nr_m_tdata);
        if (nr_invalid) nr_inv_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [2:0] size, input logic [4:0] data);
        s_tsize  = size;
        s_tdata  = data;
        s_tvalid = 1'b1;
        tick(1);
        s_tvalid = 1'b0;
    endtask

    task automatic nr_send(input logic [2:0] size, input logic [4:0] data);
        nr_tsize  = size;
        nr_tdata  = data;
        nr_tvalid = 1'b1;
        tick(1);
        nr_tvalid = 1'b0;
    endtask

    task automatic compare_stream(input string tag);
        check_eq({tag, "_count"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            check_eq($sformatf("%s_byte%0d", tag, i), cap_q[i], exp_q[i]);
        end
        cap_q.delete();
        exp_q.delete();
    endtask

    initial begin
        resetn = 1'b0;
        s_tvalid = 1'b0; s_tdata = '0; s_tsize = '0; m_tready = 1'b0;
        nr_tvalid = 1'b0; nr_tdata = '0; nr_tsize = '0; nr_m_tready = 1'b1;
        tick(3);
        check_eq("rst_tvalid", m_tvalid, 0);
        check_eq("rst_tdata", m_tdata, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_drops", drop_cnt, 0);
        check_eq("rst_invalid", invalid, 0);
        resetn = 1'b1;
        tick(2);

        // letters and digits, first-byte latency
        m_tready = 1'b1;
        send(3'd2, 5'b00001);
        check_eq("lat_n1_tvalid", m_tvalid, 0);
        send(3'd1, 5'b00001);
        check_eq("lat_n2_tvalid", m_tvalid, 1);
        check_eq("lat_n2_tdata", m_tdata, 8'h41);
        send(3'd5, 5'b11111);
        send(3'd5, 5'b11110);
        tick(5);
        exp_q = '{8'h41, 8'h54, 8'h30, 8'h39};
        compare_stream("letters");

        // word gap, ignored upper bits, more table entries
        send(3'd0, 5'b10101);
        send(3'd1, 5'b11110);
        send(3'd5, 5'b00000);
        send(3'd4, 5'b01100);
        tick(5);
        exp_q = '{8'h20, 8'h45, 8'h35, 8'h5A};
        compare_stream("gap");
        check_eq("no_invalid_yet", inv_cnt, 0);

        // invalid patterns with replacement
        inv_cnt = 0;
        send(3'd4, 5'b00011);
        check_eq("inv_pulse_hi", invalid, 1);
        tick(1);
        check_eq("inv_pulse_lo", invalid, 0);
        tick(3);
        check_eq("inv_once", inv_cnt, 1);
        send(3'd5, 5'b01010);
        send(3'd7, 5'b11111);
        tick(5);
        exp_q = '{8'h3F, 8'h3F, 8'h3F};
        compare_stream("replace");
        check_eq("inv_three", inv_cnt, 3);

        // invalid pattern without replacement
        nr_send(3'd6, 5'b00000);
        tick(5);
        check_eq("nr_inv_once", nr_inv_cnt, 1);
        check_eq("nr_no_output", nr_cap_q.size(), 0);
        check_eq("nr_level", nr_level, 0);
        nr_send(3'd1, 5'b00001);
        tick(5);
        check_eq("nr_valid_count", nr_cap_q.size(), 1);
        if (nr_cap_q.size() > 0) check_eq("nr_valid_byte", nr_cap_q[0], 8'h54);

        // overflow
        check_eq("pre_ovf_flag", overflow, 0);
        m_tready = 1'b0;
        repeat (10) send(3'd1, 5'b00000);
        tick(3);
        check_eq("ovf_level", level, 8);
        check_eq("ovf_flag", overflow, 1);
        check_eq("ovf_drops", drop_cnt, 2);
        check_eq("ovf_stall_tvalid", m_tvalid, 1);
        check_eq("ovf_stall_tdata", m_tdata, 8'h45);
        m_tready = 1'b1;
        tick(12);
        repeat (8) exp_q.push_back(8'h45);
        compare_stream("ovf_drain");
        check_eq("ovf_drain_level", level, 0);
        check_eq("ovf_sticky", overflow, 1);

        // full with simultaneous push and pop
        m_tready = 1'b0;
        send(3'd2, 5'b00001);
        send(3'd2, 5'b00010);
        send(3'd1, 5'b00000);
        send(3'd1, 5'b00001);
        send(3'd3, 5'b00000);
        send(3'd3, 5'b00111);
        send(3'd3, 5'b00101);
        send(3'd4, 5'b01101);
        tick(3);
        check_eq("full_level", level, 8);
        send(3'd4, 5'b01001);
        m_tready = 1'b1;
        tick(1);
        m_tready = 1'b0;
        check_eq("full_pp_level", level, 8);
        check_eq("full_pp_drops", drop_cnt, 2);
        m_tready = 1'b1;
        tick(12);
        exp_q = '{8'h41, 8'h4E, 8'h45, 8'h54, 8'h53, 8'h4F, 8'h4B, 8'h51, 8'h58};
        compare_stream("full_pp");
        check_eq("full_pp_empty", level, 0);

        // reset mid-stream
        m_tready = 1'b0;
        send(3'd2, 5'b00001);
        send(3'd1, 5'b00001);
        send(3'd1, 5'b00000);
        tick(3);
        check_eq("mid_level", level, 3);
        resetn = 1'b0;
        #2;
        check_eq("mid_rst_tvalid", m_tvalid, 0);
        check_eq("mid_rst_level", level, 0);
        check_eq("mid_rst_overflow", overflow, 0);
        check_eq("mid_rst_drops", drop_cnt, 0);
        tick(1);
        resetn = 1'b1;
        tick(1);
        cap_q.delete();
        m_tready = 1'b1;
        send(3'd2, 5'b00001);
        check_eq("post_rst_n1", m_tvalid, 0);
        tick(1);
        check_eq("post_rst_n2_tvalid", m_tvalid, 1);
        check_eq("post_rst_n2_tdata", m_tdata, 8'h41);
        tick(3);
        exp_q = '{8'h41};
        compare_stream("post_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/morse_char_decoder.md
Name: morse_char_decoder

Overview:
- Downstream of the symbol receiver.
- Consumes the one-cycle character beat (tvalid/tdata/tsize) and translates the dot/dash pattern into 8-bit ASCII through a registered lookup.
- Buffers results in a small FIFO and presents them on a valid/ready stream to the UART/display sink.
- Flags undecodable patterns and FIFO overflow.

Parameters:
- FIFO_DEPTH, 8, number of ASCII entries buffered; power of two, at least 2.
- REPLACE_INVALID, 1, 1 = emit '?' (0x3F) for undecodable patterns; 0 = drop them.
- SPACE_CHAR, 8'h20, ASCII code emitted for a word-gap beat.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- s_tvalid_i  input  1  character beat from symbol receiver, single-cycle pulse, no backpressure
- s_tdata_i  input  MORSE_CHAR_WIDTH_MAX_C (5)  symbol pattern, 1 = dash, 0 = dot
- s_tsize_i  input  MORSE_SIZE_WIDTH_MAX_C (3)  number of valid symbols; 0 = word gap
- m_tvalid_o  output  1  ASCII byte available
- m_tdata_o  output  8  ASCII byte
- m_tready_i  input  1  sink accepts byte
- invalid_o  output  1  one-cycle pulse per undecodable pattern
- overflow_o  output  1  sticky, set on any drop due to full FIFO
- drop_cnt_o  output  8  saturating count of FIFO-full drops
- level_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: all outputs 0, FIFO empty, pipeline register empty, counters 0. Reset asserted mid-transfer discards all buffered data immediately.
- Bit ordering:
  - First received symbol is s_tdata_i[s_tsize_i-1]; last is s_tdata_i[0].
  - Bits at or above s_tsize_i are ignored.
  - Examples: A (.-) = size 2, data 5'b00001. N (-.) = size 2, data 5'b00010. E = size 1, data 0. T = size 1, data 1. 0 (-----) = size 5, data 5'b11111. 5 (.....) = size 5, data 0.
- Decode set:
  - Letters A–Z map to uppercase 0x41–0x5A.
  - Digits 0–9 map to 0x30–0x39.
  - size 0 maps to SPACE_CHAR.
  - Every other size 1–5 pattern is invalid (e.g. size 4 ..-- / 0011, size 5 .-.-. / 01010).
  - size 6 and 7 are invalid.
- Stage 1, cycle N+1: on s_tvalid_i in cycle N, register the decoded byte and a valid/invalid tag.
- Stage 2, cycle N+1 edge into N+2:
  - Valid byte, or invalid with REPLACE_INVALID=1 (byte 0x3F): push into FIFO.
  - Invalid with REPLACE_INVALID=0: no push.
  - invalid_o pulses in cycle N+1 for every invalid pattern, independent of REPLACE_INVALID.
- Latency: input beat in cycle N → m_tvalid_o high in cycle N+2 when the FIFO was empty.
- Input beats may arrive every cycle. The pipeline never stalls; stage 1 is overwritten each beat.
- Output handshake:
  - A byte transfers on a cycle with m_tvalid_o && m_tready_i.
  - m_tdata_o is stable while m_tvalid_o is high and m_tready_i is low.
  - m_tvalid_o never deasserts without a transfer.
  - m_tdata_o is the FIFO head, driven combinationally from the FIFO.
- Full:
  - A push while level == FIFO_DEPTH and no pop that cycle is dropped.
  - On a drop: overflow_o sets (sticky until reset) and drop_cnt_o increments, saturating at 255.
  - Push and pop in the same cycle while full: both succeed, level unchanged, no drop.
- Empty: m_tvalid_o low. Push and pop cannot coincide while empty, because pop requires m_tvalid_o; no bypass path.
- level_o: updated the cycle after push/pop (+1 push only, −1 pop only, unchanged for both).
- Pointers: read/write pointers wrap modulo FIFO_DEPTH. Full/empty are derived from level, not from pointer equality alone.

Test Plan:
- Letters and digits: beats A (2, 00001), T (1, 1), 0 (5, 11111), 9 (5, 11110) with m_tready_i=1 → stream 0x41, 0x54, 0x30, 0x39; first m_tvalid_o exactly 2 cycles after first beat.
- Word gap and upper bits: beat size 0 → 0x20; beat size 1 with data 5'b11110 → 0x45 ('E'), confirming bits ≥ size are ignored.
- Invalid patterns:
  - REPLACE_INVALID=1: size 4 / 0011 → 0x3F emitted and invalid_o pulses once.
  - REPLACE_INVALID=0: size 6 / 0 → no output and invalid_o pulses once.
- Overflow: m_tready_i=0, FIFO_DEPTH=8, 10 beats of E → level_o=8, overflow_o=1, drop_cnt_o=2. Then m_tready_i=1 → exactly eight 0x45 bytes.
- Full with simultaneous traffic: FIFO full, m_tready_i=1 in the same cycle a push reaches stage 2 → no drop, level_o stays 8, output order preserved.
- Reset mid-stream: 3 bytes buffered, m_tready_i=0, pulse resetn low → m_tvalid_o=0, level_o=0, overflow_o=0, drop_cnt_o=0; next beat A → 0x41 after 2 cycles.
